// File: rtl/mailbox_pkg.sv
// Shared types and widths for the mailbox sequencing controller.
package mailbox_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      DISCARD = 2'd2,
      PENDING = 2'd3
   } mbx_state_e;

   localparam int MBX_DATA_W    = 32;
   localparam int MBX_MAX_DEPTH = 8;
   localparam int MBX_SEL_W     = 3;

endpackage

// File: rtl/mailbox_ctrl_if.sv
// Bundle between mailbox_ctrl and its surroundings: sender stream, receiver
// port, status outputs and the mailbox_mem strobes.
interface mailbox_ctrl_if #(
   parameter int CNT_W = 16
);
   import mailbox_pkg::*;

   // Sender stream: a word moves when s_valid and s_ready are both high on a
   // rising clk; the sender holds s_data/s_last stable until that happens.
   logic                  s_valid;
   logic [MBX_DATA_W-1:0] s_data;
   logic                  s_last;
   logic                  s_ready;

   logic                  r_req;
   logic [MBX_SEL_W-1:0]  r_addr;
   logic [MBX_DATA_W-1:0] r_data;
   logic                  r_valid;
   logic                  r_ack;

   logic                  irq;
   logic [3:0]            msg_len;
   logic                  err_trunc;
   logic [CNT_W-1:0]      msg_count;

   logic                  mb_wr;
   logic [MBX_SEL_W-1:0]  mb_wr_sel;
   logic [MBX_DATA_W-1:0] mb_wdata;
   logic                  mb_wr_ready;
   logic                  mb_rd;
   logic [3:0]            mb_rd_sel;
   logic [MBX_DATA_W-1:0] mb_rdata;
   logic                  mb_rvalid;

   mbx_state_e            dbg_state;

   modport slave (
      input  s_valid, s_data, s_last, r_req, r_addr, r_ack,
             mb_wr_ready, mb_rdata, mb_rvalid,
      output s_ready, r_data, r_valid, irq, msg_len, err_trunc, msg_count,
             mb_wr, mb_wr_sel, mb_wdata, mb_rd, mb_rd_sel, dbg_state
   );

   modport master (
      output s_valid, s_data, s_last, r_req, r_addr, r_ack,
             mb_wr_ready, mb_rdata, mb_rvalid,
      input  s_ready, r_data, r_valid, irq, msg_len, err_trunc, msg_count,
             mb_wr, mb_wr_sel, mb_wdata, mb_rd, mb_rd_sel, dbg_state
   );

endinterface

// File: rtl/mailbox_ctrl.sv
// Sequences one mailbox_mem between a streaming sender and a random-access
// receiver: fill, doorbell, read, acknowledge.
module mailbox_ctrl
   import mailbox_pkg::*;
#(
   parameter int MESSAGE_DEPTH = 4,
   parameter int CNT_W         = 16
) (
   input logic            clk,
   input logic            reset,
   mailbox_ctrl_if.slave  mbx
);

   localparam logic [MBX_SEL_W-1:0] LAST_PTR  = MBX_SEL_W'(MESSAGE_DEPTH - 1);
   localparam logic [3:0]           DEPTH_LEN = 4'(MESSAGE_DEPTH);

   mbx_state_e            state_q;
   logic [MBX_SEL_W-1:0]  wr_ptr_q;
   logic [3:0]            msg_len_q;
   logic                  irq_q;
   logic                  r_valid_q;
   logic [MBX_DATA_W-1:0] r_data_q;
   logic                  err_trunc_q;
   logic [CNT_W-1:0]      msg_count_q;

   logic                  accept;
   logic                  rd_hit;
   logic                  unused_rvalid;

   // Memory read data is combinational, so its valid flag carries no extra information.
   assign unused_rvalid = mbx.mb_rvalid;

   assign mbx.s_ready   = !reset && mbx.mb_wr_ready && (state_q != PENDING);
   assign accept        = mbx.s_valid && mbx.s_ready;
   assign mbx.mb_wr     = accept && ((state_q == IDLE) || (state_q == FILL));
   assign mbx.mb_wr_sel = wr_ptr_q;
   assign mbx.mb_wdata  = mbx.s_data;

   assign rd_hit        = (state_q == PENDING) && ({1'b0, mbx.r_addr} < msg_len_q);
   assign mbx.mb_rd     = !reset && mbx.r_req && rd_hit;
   assign mbx.mb_rd_sel = {1'b0, mbx.r_addr};

   assign mbx.irq       = irq_q;
   assign mbx.msg_len   = msg_len_q;
   assign mbx.r_valid   = r_valid_q;
   assign mbx.r_data    = r_data_q;
   assign mbx.err_trunc = err_trunc_q;
   assign mbx.msg_count = msg_count_q;
   assign mbx.dbg_state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         msg_len_q   <= '0;
         irq_q       <= 1'b0;
         r_valid_q   <= 1'b0;
         r_data_q    <= '0;
         err_trunc_q <= 1'b0;
         msg_count_q <= '0;
      end else begin
         err_trunc_q <= 1'b0;
         r_valid_q   <= mbx.r_req;
         if (mbx.r_req) begin
            r_data_q <= mbx.mb_rd ? mbx.mb_rdata : '0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (mbx.s_last) begin
                     msg_len_q <= 4'd1;
                     irq_q     <= 1'b1;
                     state_q   <= PENDING;
                  end else if (MESSAGE_DEPTH == 1) begin
                     msg_len_q   <= 4'd1;
                     err_trunc_q <= 1'b1;
                     state_q     <= DISCARD;
                  end else begin
                     wr_ptr_q <= MBX_SEL_W'(1);
                     state_q  <= FILL;
                  end
               end
            end
            FILL: begin
               if (accept) begin
                  if (mbx.s_last) begin
                     msg_len_q <= {1'b0, wr_ptr_q} + 4'd1;
                     irq_q     <= 1'b1;
                     state_q   <= PENDING;
                  end else if (wr_ptr_q == LAST_PTR) begin
                     msg_len_q   <= DEPTH_LEN;
                     err_trunc_q <= 1'b1;
                     state_q     <= DISCARD;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + MBX_SEL_W'(1);
                  end
               end
            end
            DISCARD: begin
               // Overflow words are drained until the sender closes the message.
               if (accept && mbx.s_last) begin
                  irq_q   <= 1'b1;
                  state_q <= PENDING;
               end
            end
            PENDING: begin
               if (mbx.r_ack) begin
                  irq_q       <= 1'b0;
                  msg_len_q   <= '0;
                  wr_ptr_q    <= '0;
                  msg_count_q <= msg_count_q + CNT_W'(1);
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mailbox_ctrl.sv
// Bench for mailbox_ctrl with a behavioural mailbox_mem beside it and a
// message-level reference model for the random phase.
module tb_mailbox_ctrl;
   import mailbox_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mailbox_ctrl_if #(.CNT_W(CNT_W)) mbx ();

   mailbox_ctrl #(.MESSAGE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .mbx   (mbx)
   );

   logic [31:0] mem [0:7];
   always @(posedge clk) if (mbx.mb_wr) mem[mbx.mb_wr_sel] <= mbx.mb_wdata;
   assign mbx.mb_rdata  = mem[mbx.mb_rd_sel[2:0]];
   assign mbx.mb_rvalid = mbx.mb_rd;

   int trunc_cnt = 0;
   always @(negedge clk) if (mbx.err_trunc === 1'b1) trunc_cnt++;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        exp_wr;
      logic [2:0]  exp_sel;
      logic        exp_trunc;
   } wr_vec_t;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] exp_data;
   } rd_vec_t;

   wr_vec_t wv3 [3];
   wr_vec_t wv6 [6];
   rd_vec_t rv  [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mbx.s_valid     = 1'b0;
      mbx.s_data      = '0;
      mbx.s_last      = 1'b0;
      mbx.r_req       = 1'b0;
      mbx.r_addr      = '0;
      mbx.r_ack       = 1'b0;
      mbx.mb_wr_ready = 1'b1;
   endtask

   // Offers one word until accepted; reports the memory strobe seen in the accept cycle.
   task automatic send_word(input logic [31:0] d, input logic last, input logic stall,
                            output logic wr, output logic [2:0] sel, output logic ok);
      mbx.s_valid = 1'b1;
      mbx.s_data  = d;
      mbx.s_last  = last;
      ok = 1'b0;
      wr = 1'b0;
      sel = '0;
      for (int c = 0; c < 60; c++) begin
         mbx.mb_wr_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (!mbx.mb_wr_ready) check("stall_s_ready", mbx.s_ready, 1'b0);
         if (mbx.s_ready) begin
            wr  = mbx.mb_wr;
            sel = mbx.mb_wr_sel;
            ok  = 1'b1;
            tick();
            break;
         end
         tick();
      end
      mbx.s_valid     = 1'b0;
      mbx.s_last      = 1'b0;
      mbx.mb_wr_ready = 1'b1;
   endtask

   task automatic read_word(input logic [2:0] a, input logic ack,
                            output logic [31:0] data, output logic vld);
      mbx.r_req  = 1'b1;
      mbx.r_addr = a;
      mbx.r_ack  = ack;
      tick();
      mbx.r_req  = 1'b0;
      mbx.r_ack  = 1'b0;
      vld  = mbx.r_valid;
      data = mbx.r_data;
   endtask

   task automatic send_table3();
      logic wr, ok;
      logic [2:0] sel;
      for (int i = 0; i < 3; i++) begin
         send_word(wv3[i].data, wv3[i].last, 1'b0, wr, sel, ok);
         check("t3_accept", ok, 1'b1);
         check("t3_wr", wr, wv3[i].exp_wr);
         if (wv3[i].exp_wr) check("t3_sel", sel, wv3[i].exp_sel);
      end
   endtask

   initial begin
      logic        wr, ok, vld;
      logic [2:0]  sel;
      logic [31:0] rd;
      int          exp_count;
      int          t0;

      for (int i = 0; i < 8; i++) mem[i] = '0;
      wv3[0] = '{32'h11, 1'b0, 1'b1, 3'd0, 1'b0};
      wv3[1] = '{32'h22, 1'b0, 1'b1, 3'd1, 1'b0};
      wv3[2] = '{32'h33, 1'b1, 1'b1, 3'd2, 1'b0};
      wv6[0] = '{32'ha1, 1'b0, 1'b1, 3'd0, 1'b0};
      wv6[1] = '{32'ha2, 1'b0, 1'b1, 3'd1, 1'b0};
      wv6[2] = '{32'ha3, 1'b0, 1'b1, 3'd2, 1'b0};
      wv6[3] = '{32'ha4, 1'b0, 1'b1, 3'd3, 1'b1};
      wv6[4] = '{32'ha5, 1'b0, 1'b0, 3'd0, 1'b0};
      wv6[5] = '{32'ha6, 1'b1, 1'b0, 3'd0, 1'b0};
      rv[0] = '{3'd0, 32'h11};
      rv[1] = '{3'd1, 32'h22};
      rv[2] = '{3'd2, 32'h33};
      rv[3] = '{3'd3, 32'h0};
      rv[4] = '{3'd4, 32'h0};
      rv[5] = '{3'd5, 32'h0};
      rv[6] = '{3'd6, 32'h0};
      rv[7] = '{3'd7, 32'h0};

      // Reset state, with sender and receiver active to show the strobes are held off.
      idle_inputs();
      reset = 1'b1;
      mbx.s_valid = 1'b1;
      mbx.r_req   = 1'b1;
      tick();
      tick();
      check("rst_s_ready", mbx.s_ready, 1'b0);
      check("rst_mb_wr", mbx.mb_wr, 1'b0);
      check("rst_mb_rd", mbx.mb_rd, 1'b0);
      check("rst_irq", mbx.irq, 1'b0);
      check("rst_msg_len", mbx.msg_len, 4'd0);
      check("rst_r_valid", mbx.r_valid, 1'b0);
      check("rst_r_data", mbx.r_data, 32'h0);
      check("rst_err_trunc", mbx.err_trunc, 1'b0);
      check("rst_msg_count", mbx.msg_count, 16'd0);
      check("rst_state", 32'(mbx.dbg_state), 32'(IDLE));
      idle_inputs();
      reset = 1'b0;
      tick();

      // Three-word message.
      send_table3();
      check("t3_irq", mbx.irq, 1'b1);
      check("t3_msg_len", mbx.msg_len, 4'd3);
      check("t3_state", 32'(mbx.dbg_state), 32'(PENDING));
      for (int i = 0; i < 8; i++) begin
         read_word(rv[i].addr, 1'b0, rd, vld);
         check("t3_rd_valid", vld, 1'b1);
         check($sformatf("t3_rd_data[%0d]", rv[i].addr), rd, rv[i].exp_data);
      end
      tick();
      check("t3_r_valid_drop", mbx.r_valid, 1'b0);

      // Sender stalls in PENDING; release with a simultaneous read of slot 0.
      mbx.s_valid = 1'b1;
      mbx.s_data  = 32'h44;
      mbx.s_last  = 1'b1;
      #1;
      check("pend_s_ready", mbx.s_ready, 1'b0);
      check("pend_mb_wr", mbx.mb_wr, 1'b0);
      read_word(3'd0, 1'b1, rd, vld);
      mbx.s_valid = 1'b1;
      check("ackrd_valid", vld, 1'b1);
      check("ackrd_data", rd, 32'h11);
      check("ack_irq", mbx.irq, 1'b0);
      check("ack_state", 32'(mbx.dbg_state), 32'(IDLE));
      check("ack_count", mbx.msg_count, 16'd1);
      #1;
      check("post_ack_s_ready", mbx.s_ready, 1'b1);
      check("post_ack_mb_wr", mbx.mb_wr, 1'b1);
      check("post_ack_sel", mbx.mb_wr_sel, 3'd0);
      tick();
      mbx.s_valid = 1'b0;
      mbx.s_last  = 1'b0;
      check("one_word_len", mbx.msg_len, 4'd1);
      check("one_word_irq", mbx.irq, 1'b1);
      read_word(3'd0, 1'b0, rd, vld);
      check("one_word_data", rd, 32'h44);
      read_word(3'd1, 1'b1, rd, vld);
      check("one_word_oob", rd, 32'h0);
      check("count2", mbx.msg_count, 16'd2);
      mbx.r_ack = 1'b1;
      tick();
      mbx.r_ack = 1'b0;
      check("idle_ack_ignored", mbx.msg_count, 16'd2);
      read_word(3'd0, 1'b0, rd, vld);
      check("idle_rd_valid", vld, 1'b1);
      check("idle_rd_data", rd, 32'h0);

      // Six words into a four-deep slot.
      t0 = trunc_cnt;
      for (int i = 0; i < 6; i++) begin
         send_word(wv6[i].data, wv6[i].last, 1'b0, wr, sel, ok);
         check("t6_accept", ok, 1'b1);
         check("t6_wr", wr, wv6[i].exp_wr);
         if (wv6[i].exp_wr) check("t6_sel", sel, wv6[i].exp_sel);
         check("t6_err_trunc", mbx.err_trunc, wv6[i].exp_trunc);
      end
      check("t6_trunc_pulses", trunc_cnt - t0, 1);
      check("t6_msg_len", mbx.msg_len, 4'd4);
      check("t6_irq", mbx.irq, 1'b1);
      read_word(3'd3, 1'b0, rd, vld);
      check("t6_slot3", rd, 32'ha4);
      read_word(3'd4, 1'b1, rd, vld);
      check("t6_slot4", rd, 32'h0);

      // Reset with a message pending, then in FILL.
      send_word(32'h77, 1'b1, 1'b0, wr, sel, ok);
      check("pre_rst_irq", mbx.irq, 1'b1);
      reset = 1'b1;
      #1;
      check("rst_pend_irq", mbx.irq, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      send_word(32'h55, 1'b0, 1'b0, wr, sel, ok);
      send_word(32'h66, 1'b0, 1'b0, wr, sel, ok);
      check("fill_state", 32'(mbx.dbg_state), 32'(FILL));
      mbx.s_valid = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_fill_s_ready", mbx.s_ready, 1'b0);
      check("rst_fill_msg_len", mbx.msg_len, 4'd0);
      check("rst_fill_irq", mbx.irq, 1'b0);
      tick();
      mbx.s_valid = 1'b0;
      reset = 1'b0;
      tick();
      send_word(32'h99, 1'b1, 1'b0, wr, sel, ok);
      check("rst_after_sel", sel, 3'd0);
      check("rst_after_len", mbx.msg_len, 4'd1);
      read_word(3'd0, 1'b1, rd, vld);
      check("rst_after_data", rd, 32'h99);

      // Random messages against a message-level model.
      exp_count = 1;
      for (int m = 0; m < 30; m++) begin
         logic [31:0] kept [$];
         int          n;
         int          k;
         n = $urandom_range(1, 7);
         kept.delete();
         t0 = trunc_cnt;
         for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            d = $urandom;
            send_word(d, (i == n - 1), 1'b1, wr, sel, ok);
            check("rnd_accept", ok, 1'b1);
            check("rnd_wr", wr, (i < DEPTH));
            if (i < DEPTH) begin
               check("rnd_sel", sel, 3'(i));
               kept.push_back(d);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
         end
         check("rnd_irq", mbx.irq, 1'b1);
         check("rnd_len", mbx.msg_len, 32'(kept.size()));
         check("rnd_trunc", trunc_cnt - t0, (n > DEPTH) ? 1 : 0);
         k = $urandom_range(1, 5);
         for (int r = 0; r < k; r++) begin
            logic [2:0] a;
            logic       ack;
            a   = 3'($urandom_range(0, 7));
            ack = (r == k - 1) && ($urandom_range(0, 1) == 1);
            read_word(a, ack, rd, vld);
            check("rnd_rd_valid", vld, 1'b1);
            check("rnd_rd_data", rd, (a < kept.size()) ? kept[a] : 32'h0);
            if (ack) exp_count++;
         end
         if (mbx.irq) begin
            mbx.r_ack = 1'b1;
            tick();
            mbx.r_ack = 1'b0;
            exp_count++;
         end
         check("rnd_irq_clear", mbx.irq, 1'b0);
         check("rnd_count", mbx.msg_count, 16'(exp_count));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
